// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register/status codes and the
// pipeline-control FSM states.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/y86_pipe_ctrl_if.sv
// Bundle between the pipeline stages and the control/status unit.
interface y86_pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  // run_req is a level, step_req a single-cycle pulse; there is no backpressure.
  // The control outputs are combinational in the same cycle as the stage inputs.
  logic             run_req;
  logic             step_req;
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [3:0]       W_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_dstM;
  logic             e_cnd;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic [3:0]       stat;
  logic [2:0]       state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mp_cnt;

  modport master (
    output run_req, step_req, D_icode, E_icode, M_icode, W_icode,
           d_srcA, d_srcB, E_dstM, e_cnd, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
           stat, state, cyc_cnt, ret_cnt, lu_cnt, mp_cnt
  );

  modport slave (
    input  run_req, step_req, D_icode, E_icode, M_icode, W_icode,
           d_srcA, d_srcB, E_dstM, e_cnd, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
           stat, state, cyc_cnt, ret_cnt, lu_cnt, mp_cnt
  );
endinterface

// File: rtl/y86_sat_cnt.sv
// Up-counter that sticks at all-ones instead of wrapping.
module y86_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end
endmodule

// File: rtl/y86_pipe_ctrl.sv
// Pipeline control and status: hazard stall/bubble generation, run/step/halt
// state machine, sticky architectural status and saturating perf counters.
module y86_pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter bit STEP_EN = 1'b1
) (
  input logic            clk,
  input logic            reset,
  y86_pipe_ctrl_if.slave bus
);
  ctrl_state_e state_q, state_d;
  logic        pend_q, pend_d;
  logic [3:0]  stat_q;
  logic        load_use, ret_haz, mispred;
  logic        step_in, active, retire, w_bad;

  assign step_in  = STEP_EN && bus.step_req;
  assign w_bad    = (bus.W_stat != STAT_AOK);
  assign load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                    (bus.E_dstM != RNONE) &&
                    ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
  assign ret_haz  = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                    (bus.M_icode == I_RET);
  assign mispred  = (bus.E_icode == I_JXX) && !bus.e_cnd;

  // Stages advance only in RUN, or in STEP while a step is outstanding.
  assign active = (state_q == ST_RUN) || ((state_q == ST_STEP) && pend_q);
  assign retire = active && (bus.W_icode != I_NOP) && !w_bad;

  always_comb begin : ctrl_out
    bus.F_stall  = 1'b1;
    bus.D_stall  = 1'b1;
    bus.W_stall  = 1'b1;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.M_bubble = 1'b0;
    bus.set_cc   = 1'b0;
    if (active) begin
      bus.F_stall  = load_use | ret_haz;
      bus.D_stall  = load_use;
      bus.D_bubble = mispred | (ret_haz & !load_use);
      bus.E_bubble = mispred | load_use;
      bus.M_bubble = (bus.m_stat != STAT_AOK) | w_bad;
      bus.W_stall  = w_bad;
      bus.set_cc   = (bus.E_icode == I_OPQ) && (bus.m_stat == STAT_AOK) && !w_bad;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run_req)  state_d = ST_RUN;
        else if (step_in) state_d = ST_STEP;
      end
      ST_RUN:  if (!bus.run_req && STEP_EN) state_d = ST_STEP;
      ST_STEP: if (bus.run_req) state_d = ST_RUN;
      default: state_d = state_q;
    endcase
    if ((state_q == ST_RUN) || (state_q == ST_STEP)) begin
      if (bus.W_stat == STAT_HLT) begin
        state_d = ST_HALTED;
      end else if ((bus.W_stat == STAT_ADR) || (bus.W_stat == STAT_INS)) begin
        state_d = ST_FAULT;
      end
    end
    // A pending step is one-shot: requests arriving while it is outstanding are dropped.
    if (pend_q && retire)      pend_d = 1'b0;
    else if (!pend_q && step_in) pend_d = 1'b1;
    if (state_d != ST_STEP) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if ((stat_q == STAT_AOK) && w_bad) stat_q <= bus.W_stat;
    end
  end

  assign bus.state = state_q;
  assign bus.stat  = stat_q;

  y86_sat_cnt #(.W(CNT_W)) u_cyc (.clk(clk), .reset(reset), .inc(active),
                                  .q(bus.cyc_cnt));
  y86_sat_cnt #(.W(CNT_W)) u_ret (.clk(clk), .reset(reset), .inc(retire),
                                  .q(bus.ret_cnt));
  y86_sat_cnt #(.W(CNT_W)) u_lu  (.clk(clk), .reset(reset), .inc(active && load_use),
                                  .q(bus.lu_cnt));
  y86_sat_cnt #(.W(CNT_W)) u_mp  (.clk(clk), .reset(reset), .inc(active && mispred),
                                  .q(bus.mp_cnt));
endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// Bench for y86_pipe_ctrl: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a behavioural model.
module tb_y86_pipe_ctrl;
  import y86_pkg::*;

  typedef struct packed {
    logic       run;
    logic       step;
    logic [3:0] d_ic, e_ic, m_ic, w_ic, src_a, src_b, dst_m;
    logic       cnd;
    logic [3:0] m_st, w_st;
  } vin_t;

  typedef struct packed {
    vin_t       in;
    logic [6:0] exp;
  } vec_t;

  logic clk, reset;
  int   n_err, n_checks;
  logic [6:0] exp_q[$];

  y86_pipe_ctrl_if #(.CNT_W(32)) bus ();
  y86_pipe_ctrl_if #(.CNT_W(4))  bus4 ();

  assign bus4.run_req  = bus.run_req;
  assign bus4.step_req = bus.step_req;
  assign bus4.D_icode  = bus.D_icode;
  assign bus4.E_icode  = bus.E_icode;
  assign bus4.M_icode  = bus.M_icode;
  assign bus4.W_icode  = bus.W_icode;
  assign bus4.d_srcA   = bus.d_srcA;
  assign bus4.d_srcB   = bus.d_srcB;
  assign bus4.E_dstM   = bus.E_dstM;
  assign bus4.e_cnd    = bus.e_cnd;
  assign bus4.m_stat   = bus.m_stat;
  assign bus4.W_stat   = bus.W_stat;

  y86_pipe_ctrl #(.CNT_W(32), .STEP_EN(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  y86_pipe_ctrl #(.CNT_W(4),  .STEP_EN(1'b1)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 step, 3 halted, 4 fault
  logic [2:0] m_mode;
  bit         m_pend;
  logic [3:0] m_stat;
  longint     m_cyc, m_ret, m_lu, m_mp;

  function automatic bit m_live();
    return (m_mode == 3'd1) || (m_mode == 3'd2 && m_pend);
  endfunction

  function automatic bit hz_lu();
    return (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
           (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
  endfunction

  function automatic bit hz_ret();
    return bus.D_icode == 4'h9 || bus.E_icode == 4'h9 || bus.M_icode == 4'h9;
  endfunction

  function automatic bit hz_mp();
    return bus.E_icode == 4'h7 && !bus.e_cnd;
  endfunction

  // order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc
  function automatic logic [6:0] exp_ctrl();
    bit lu, rh, mp, wb;
    lu = hz_lu();
    rh = hz_ret();
    mp = hz_mp();
    wb = bus.W_stat != 4'b1000;
    if (!m_live()) return 7'b1100010;
    return {lu | rh, lu, mp | (rh & !lu), mp | lu, (bus.m_stat != 4'b1000) | wb, wb,
            bus.E_icode == 4'h6 && bus.m_stat == 4'b1000 && !wb};
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = 3'd0; m_pend = 1'b0; m_stat = 4'b1000;
    m_cyc = 0; m_ret = 0; m_lu = 0; m_mp = 0;
  endtask

  task automatic model_edge();
    bit live, ret;
    logic [2:0] nxt;
    live = m_live();
    ret  = live && bus.W_icode != 4'h1 && bus.W_stat == 4'b1000;
    if (live) begin
      m_cyc += 1;
      m_lu  += longint'(hz_lu());
      m_mp  += longint'(hz_mp());
      m_ret += longint'(ret);
    end
    if (m_stat == 4'b1000) m_stat = bus.W_stat;
    nxt = m_mode;
    if (m_mode == 3'd1 || m_mode == 3'd2) begin
      if (bus.W_stat == 4'b0100) nxt = 3'd3;
      else if (bus.W_stat == 4'b0010 || bus.W_stat == 4'b0001) nxt = 3'd4;
      else if (m_mode == 3'd1 && !bus.run_req) nxt = 3'd2;
      else if (m_mode == 3'd2 && bus.run_req) nxt = 3'd1;
    end else if (m_mode == 3'd0) begin
      nxt = bus.run_req ? 3'd1 : (bus.step_req ? 3'd2 : 3'd0);
    end
    if (m_pend && ret) m_pend = 1'b0;
    else if (!m_pend && bus.step_req) m_pend = 1'b1;
    if (nxt != 3'd2) m_pend = 1'b0;
    m_mode = nxt;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctrl_of_dut();
    return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble,
            bus.W_stall, bus.set_cc};
  endfunction

  function automatic logic [6:0] ctrl_of_dut4();
    return {bus4.F_stall, bus4.D_stall, bus4.D_bubble, bus4.E_bubble, bus4.M_bubble,
            bus4.W_stall, bus4.set_cc};
  endfunction

  task automatic check_all();
    chk("ctrl",  64'(ctrl_of_dut()),  64'(exp_ctrl()));
    chk("ctrl4", 64'(ctrl_of_dut4()), 64'(exp_ctrl()));
    chk("state", 64'(bus.state), 64'(m_mode));
    chk("stat",  64'(bus.stat),  64'(m_stat));
    chk("cyc",   64'(bus.cyc_cnt), sat(m_cyc, 32));
    chk("ret",   64'(bus.ret_cnt), sat(m_ret, 32));
    chk("lu",    64'(bus.lu_cnt),  sat(m_lu, 32));
    chk("mp",    64'(bus.mp_cnt),  sat(m_mp, 32));
    chk("cyc4",  64'(bus4.cyc_cnt), sat(m_cyc, 4));
    chk("ret4",  64'(bus4.ret_cnt), sat(m_ret, 4));
    chk("lu4",   64'(bus4.lu_cnt),  sat(m_lu, 4));
    chk("mp4",   64'(bus4.mp_cnt),  sat(m_mp, 4));
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input vin_t v);
    bus.run_req  = v.run;
    bus.step_req = v.step;
    bus.D_icode  = v.d_ic;
    bus.E_icode  = v.e_ic;
    bus.M_icode  = v.m_ic;
    bus.W_icode  = v.w_ic;
    bus.d_srcA   = v.src_a;
    bus.d_srcB   = v.src_b;
    bus.E_dstM   = v.dst_m;
    bus.e_cnd    = v.cnd;
    bus.m_stat   = v.m_st;
    bus.W_stat   = v.w_st;
  endtask

  function automatic vin_t mk(input logic [3:0] d, e, m, w, sa, sb, dm,
                              input logic c, input logic [3:0] ms, ws);
    vin_t v;
    v.run = 1'b1; v.step = 1'b0;
    v.d_ic = d; v.e_ic = e; v.m_ic = m; v.w_ic = w;
    v.src_a = sa; v.src_b = sb; v.dst_m = dm;
    v.cnd = c; v.m_st = ms; v.w_st = ws;
    return v;
  endfunction

  task automatic cycle();
    @(negedge clk);
    check_all();
    if (exp_q.size() > 0) chk("vec", 64'(ctrl_of_dut()), 64'(exp_q.pop_front()));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    vin_t v;
    v = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8);
    v.run = 1'b0;
    apply(v);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t       tbl[13];
  logic [3:0] ics[9];

  initial begin
    vin_t v;
    n_err = 0;
    n_checks = 0;
    reset = 1'b1;

    tbl[0]  = '{mk(4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8), 7'b0000000};
    tbl[1]  = '{mk(4'h1, 4'h5, 4'h1, 4'h2, 4'h3, 4'h0, 4'h3, 1'b1, 4'h8, 4'h8), 7'b1101000};
    tbl[2]  = '{mk(4'h1, 4'hB, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 1'b1, 4'h8, 4'h8), 7'b1101000};
    tbl[3]  = '{mk(4'h1, 4'h5, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 4'h8), 7'b0000000};
    tbl[4]  = '{mk(4'h1, 4'h7, 4'h1, 4'h2, 4'h0, 4'h1, 4'hF, 1'b0, 4'h8, 4'h8), 7'b0011000};
    tbl[5]  = '{mk(4'h1, 4'h7, 4'h1, 4'h2, 4'h0, 4'h1, 4'hF, 1'b1, 4'h8, 4'h8), 7'b0000000};
    tbl[6]  = '{mk(4'h1, 4'h1, 4'h9, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8), 7'b1010000};
    tbl[7]  = '{mk(4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8), 7'b0000000};
    tbl[8]  = '{mk(4'h9, 4'h5, 4'h1, 4'h2, 4'h2, 4'h0, 4'h2, 1'b1, 4'h8, 4'h8), 7'b1101000};
    tbl[9]  = '{mk(4'h1, 4'h6, 4'h1, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8), 7'b0000001};
    tbl[10] = '{mk(4'h1, 4'h6, 4'h1, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h2, 4'h8), 7'b0000100};
    tbl[11] = '{mk(4'h9, 4'h7, 4'h1, 4'h1, 4'h3, 4'h0, 4'hF, 1'b0, 4'h8, 4'h8), 7'b1011000};
    tbl[12] = '{mk(4'h1, 4'hB, 4'h9, 4'h2, 4'h5, 4'h5, 4'h5, 1'b0, 4'h8, 4'h8), 7'b1101000};

    ics = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};

    // reset state, then one IDLE cycle with run_req to enter RUN
    do_reset();
    apply(mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8));
    cycle();

    // directed hazard vectors in RUN
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].in);
      exp_q.push_back(tbl[i].exp);
      cycle();
    end
    chk("tbl_lu", 64'(bus.lu_cnt), 64'd4);
    chk("tbl_mp", 64'(bus.mp_cnt), 64'd2);

    // single step: one retirement then frozen, second request while pending dropped
    do_reset();
    v = mk(4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8);
    v.run = 1'b0;
    apply(v); cycle();
    v.step = 1'b1; apply(v); cycle();
    v.step = 1'b0; apply(v); cycle();
    v.step = 1'b1; v.w_ic = 4'h2; apply(v); cycle();
    v.step = 1'b0; apply(v); cycle(); cycle();
    chk("step_ret",   64'(bus.ret_cnt), 64'd1);
    chk("step_state", 64'(bus.state), 64'd2);
    chk("step_frz",   64'(ctrl_of_dut()), 64'(7'b1100010));

    // halt then a later fault code: status must keep HLT, counters frozen
    do_reset();
    v = mk(4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8);
    apply(v); cycle(); cycle(); cycle();
    v.w_st = 4'b0100; apply(v); cycle();
    chk("halt_state", 64'(bus.state), 64'd3);
    chk("halt_stat",  64'(bus.stat), 64'(4'b0100));
    v.w_st = 4'b0010; apply(v); cycle(); cycle(); cycle();
    chk("halt_keep",  64'(bus.stat), 64'(4'b0100));
    chk("halt_cyc",   64'(bus.cyc_cnt), 64'd3);
    chk("halt_ret",   64'(bus.ret_cnt), 64'd2);

    // INS fault
    do_reset();
    v = mk(4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8);
    apply(v); cycle(); cycle();
    v.w_st = 4'b0001; apply(v); cycle();
    chk("fault_state", 64'(bus.state), 64'd4);
    chk("fault_stat",  64'(bus.stat), 64'(4'b0001));

    // async reset mid-RUN takes effect before the next edge
    do_reset();
    v = mk(4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8);
    apply(v); cycle(); cycle(); cycle();
    apply(mk(4'h1, 4'h5, 4'h1, 4'h2, 4'h3, 4'h0, 4'h3, 1'b1, 4'h8, 4'h8));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ctrl",  64'(ctrl_of_dut()), 64'(7'b1100010));
    chk("arst_state", 64'(bus.state), 64'd0);
    chk("arst_cyc",   64'(bus.cyc_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // saturation: 1 IDLE cycle + 20 RUN cycles
    do_reset();
    apply(mk(4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'hF, 1'b1, 4'h8, 4'h8));
    repeat (21) cycle();
    chk("sat_cyc32", 64'(bus.cyc_cnt), 64'd20);
    chk("sat_cyc4",  64'(bus4.cyc_cnt), 64'd15);

    // randomized traffic against the model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        v.run   = ($urandom_range(0, 3) != 0);
        v.step  = ($urandom_range(0, 3) == 0);
        v.d_ic  = ics[$urandom_range(0, 8)];
        v.e_ic  = ics[$urandom_range(0, 8)];
        v.m_ic  = ics[$urandom_range(0, 8)];
        v.w_ic  = ($urandom_range(0, 2) == 0) ? 4'h1 : ics[$urandom_range(0, 8)];
        v.src_a = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
        v.src_b = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
        v.dst_m = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
        v.cnd   = 1'($urandom_range(0, 1));
        v.m_st  = ($urandom_range(0, 5) == 0) ? 4'b0010 : 4'b1000;
        v.w_st  = 4'b1000;
        if (i >= 70) begin
          case ($urandom_range(0, 5))
            0: v.w_st = 4'b0100;
            1: v.w_st = 4'b0010;
            2: v.w_st = 4'b0001;
            default: v.w_st = 4'b1000;
          endcase
        end
        apply(v);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
